mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (I) and the load/store path (D).
//  D carries the store formatter's aligned write data and byte mask.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and memory.
// slave = arbiter side, master = environment side.
interface mem_port_arbiter_if;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address,
    input  d_wdata, d_wmask,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address,
    output mem_wdata, mem_wmask,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address,
    output d_wdata, d_wmask,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address,
    input  mem_wdata, mem_wmask,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D).
// D has priority; a streak counter lets I win after STREAK_MAX D grants.
module mem_port_arbiter #(
  parameter int STREAK_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              timeout_err,
  output logic              proto_err
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int WW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);
  localparam logic [WW-1:0] TLAST =
    WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wait_cnt;
  logic          d_pend;
  logic          d_win;

  assign d_pend = bus.d_read | bus.d_write;
  assign d_win  = d_pend & ((streak < SMAX) | ~bus.i_read);

  // Completions pass straight through to whoever holds the grant.
  assign bus.i_resp  = bus.mem_resp & (state == GRANT_I);
  assign bus.d_resp  = bus.mem_resp & (state == GRANT_D);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  // Grant FSM with registered strobes, latched bus and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      streak          <= '0;
      wait_cnt        <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wmask   <= '0;
      timeout_err     <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.d_read & bus.d_write)
            proto_err <= 1'b1;
          if (d_win) begin
            state           <= GRANT_D;
            bus.mem_write   <= bus.d_write;
            bus.mem_read    <= ~bus.d_write;
            bus.mem_address <= bus.d_address;
            bus.mem_wdata   <=
              bus.d_write ? bus.d_wdata : '0;
            bus.mem_wmask   <=
              bus.d_write ? bus.d_wmask : '0;
            if (!bus.i_read)
              streak <= '0;
            else if (streak != SMAX)
              streak <= streak + 1'b1;
          end else if (bus.i_read) begin
            state           <= GRANT_I;
            bus.mem_read    <= 1'b1;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= bus.i_address;
            bus.mem_wdata   <= '0;
            bus.mem_wmask   <= '0;
            streak          <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.mem_resp) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (wait_cnt >= TLAST)
              timeout_err <= 1'b1;
            else
              wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  logic timeout_err;
  logic proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .STREAK_MAX(SMAX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .timeout_err(timeout_err),
    .proto_err(proto_err)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_on = 1'b0;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  name, got, exp, $time);
  endtask

  // Model: who owns the port (0 none, 1 I, 2 D) and what it latched.
  int          m_owner;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  int          m_streak;
  int          m_busy;
  bit          m_to;
  bit          m_proto;
  int          grants[$];

  always @(posedge clk) begin
    if (rst) begin
      m_owner  = 0;
      m_wr     = 0;
      m_streak = 0;
      m_busy   = 0;
      m_to     = 0;
      m_proto  = 0;
    end else if (m_owner == 0) begin
      m_busy = 0;
      if (bus.d_read && bus.d_write) m_proto = 1;
      if ((bus.d_read || bus.d_write) &&
          (m_streak < SMAX || !bus.i_read)) begin
        m_owner = 2;
        m_wr    = bus.d_write;
        m_addr  = bus.d_address;
        m_wdata = bus.d_wdata;
        m_wmask = bus.d_write ? bus.d_wmask : 4'b0000;
        if (bus.i_read)
          m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
        else
          m_streak = 0;
        grants.push_back(2);
      end else if (bus.i_read) begin
        m_owner  = 1;
        m_wr     = 0;
        m_addr   = bus.i_address;
        m_wmask  = 4'b0000;
        m_streak = 0;
        grants.push_back(1);
      end
    end else if (bus.mem_resp) begin
      m_owner = 0;
    end else begin
      m_busy++;
      if (m_busy >= TMO) m_to = 1;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("mem_read", bus.mem_read,
          (m_owner == 1) || (m_owner == 2 && !m_wr));
      chk("mem_write", bus.mem_write, m_owner == 2 && m_wr);
      chk("i_resp", bus.i_resp, bus.mem_resp && m_owner == 1);
      chk("d_resp", bus.d_resp, bus.mem_resp && m_owner == 2);
      chk("timeout_err", timeout_err, m_to);
      chk("proto_err", proto_err, m_proto);
      if (m_owner != 0) begin
        chk("mem_address", bus.mem_address, m_addr);
        chk("mem_wmask", bus.mem_wmask, m_wmask);
        if (m_wr) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (bus.i_resp) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
      if (bus.d_resp) chk("d_rdata", bus.d_rdata, bus.mem_rdata);
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  int dq[$];
  int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
  int n;
  bit stall;
  bit resp_now;
  bit strobe;

  initial begin
    rst           = 1'b1;
    bus.i_read    = 0;
    bus.i_address = 0;
    bus.d_read    = 0;
    bus.d_write   = 0;
    bus.d_address = 0;
    bus.d_wdata   = 0;
    bus.d_wmask   = 0;
    bus.mem_rdata = 0;
    bus.mem_resp  = 0;
    go();
    cmp_on = 1'b1;
    go();
    mid();
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_errs", {timeout_err, proto_err}, 0);
    go();
    rst = 1'b0;

    // 1: fetch only
    bus.i_read    = 1;
    bus.i_address = 32'h60;
    mid();
    chk("t1_c0_no_strobe", bus.mem_read, 0);
    go(); mid();
    chk("t1_c1_read", bus.mem_read, 1);
    chk("t1_c1_addr", bus.mem_address, 32'h60);
    go(); go(); go();
    bus.mem_resp  = 1;
    bus.mem_rdata = 32'hDEADBEEF;
    mid();
    chk("t1_c4_i_resp", bus.i_resp, 1);
    chk("t1_c4_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    go();
    bus.mem_resp = 0;
    bus.i_read   = 0;
    mid();
    chk("t1_c5_idle", bus.mem_read, 0);
    chk("t1_c5_model_idle", m_owner, 0);
    go();

    // 2: store with a 3-cycle stall
    bus.d_write   = 1;
    bus.d_address = 32'h102;
    bus.d_wdata   = 32'h00AB0000;
    bus.d_wmask   = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      go(); mid();
      chk("t2_write", bus.mem_write, 1);
      chk("t2_addr", bus.mem_address, 32'h102);
      chk("t2_wdata", bus.mem_wdata, 32'h00AB0000);
      chk("t2_wmask", bus.mem_wmask, 4'b0100);
    end
    go();
    bus.mem_resp = 1;
    mid();
    chk("t2_d_resp", bus.d_resp, 1);
    go();
    bus.mem_resp = 0;
    bus.d_write  = 0;
    go();

    // 3: I and D together, D first, then I
    bus.i_read    = 1;
    bus.d_read    = 1;
    bus.d_address = 32'h200;
    go(); mid();
    chk("t3_d_first", bus.mem_address, 32'h200);
    chk("t3_d_wmask", bus.mem_wmask, 0);
    go();
    bus.mem_resp = 1;
    mid();
    chk("t3_d_resp", bus.d_resp, 1);
    chk("t3_no_i_resp", bus.i_resp, 0);
    go();
    bus.mem_resp = 0;
    bus.d_read   = 0;
    go(); mid();
    chk("t3_i_next", bus.mem_address, 32'h60);
    chk("t3_i_read", bus.mem_read, 1);
    go();
    bus.mem_resp = 1;
    mid();
    chk("t3_i_resp", bus.i_resp, 1);
    go();
    bus.mem_resp = 0;
    bus.i_read   = 0;
    go();

    // 4: streak fairness with both held
    dq.delete();
    grants.delete();
    bus.i_read    = 1;
    bus.d_read    = 1;
    bus.d_address = 32'h1000;
    n     = 0;
    stall = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      mid();
      resp_now = bus.mem_resp;
      strobe   = bus.mem_read | bus.mem_write;
      if (bus.i_resp) begin dq.push_back(1); n++; end
      if (bus.d_resp) begin dq.push_back(2); n++; end
      go();
      bus.mem_resp = 0;
      if (resp_now) begin
        stall = 0;
        if (dq.size() > 0 && dq[dq.size()-1] == 1)
          bus.i_read = 0;
        else
          bus.d_address = bus.d_address + 4;
      end else if (strobe) begin
        if (stall) begin
          bus.mem_resp = 1;
          stall = 0;
        end else begin
          stall = 1;
        end
      end
    end
    bus.i_read = 0;
    bus.d_read = 0;
    chk("t4_grant_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < dq.size()) chk("t4_dut_seq", dq[i], exp_seq[i]);
      else chk("t4_dut_seq_missing", 0, exp_seq[i]);
      if (i < grants.size())
        chk("t4_model_seq", grants[i], exp_seq[i]);
      else chk("t4_model_seq_missing", 0, exp_seq[i]);
    end
    go(); go();

    // 5: read+write together, then watchdog
    bus.d_read    = 1;
    bus.d_write   = 1;
    bus.d_address = 32'h300;
    bus.d_wdata   = 32'h11223344;
    bus.d_wmask   = 4'hF;
    go(); mid();
    chk("t5_write", bus.mem_write, 1);
    chk("t5_no_read", bus.mem_read, 0);
    chk("t5_proto", proto_err, 1);
    for (int c = 2; c <= 8; c++) go();
    mid();
    chk("t5_c8_no_timeout", timeout_err, 0);
    go(); mid();
    chk("t5_c9_timeout", timeout_err, 1);
    go();
    bus.mem_resp = 1;
    mid();
    chk("t5_d_resp", bus.d_resp, 1);
    go();
    bus.mem_resp = 0;
    bus.d_read   = 0;
    bus.d_write  = 0;
    go(); mid();
    chk("t5_proto_sticky", proto_err, 1);
    chk("t5_timeout_sticky", timeout_err, 1);

    // 6: reset during a D grant
    go();
    bus.d_read    = 1;
    bus.d_address = 32'h400;
    go(); mid();
    chk("t6_granted", bus.mem_read, 1);
    go();
    rst = 1'b1;
    go();
    rst        = 1'b0;
    bus.d_read = 0;
    mid();
    chk("t6_strobes", {bus.mem_read, bus.mem_write}, 0);
    chk("t6_addr", bus.mem_address, 0);
    chk("t6_errs", {timeout_err, proto_err}, 0);
    go();
    bus.mem_resp = 1;
    mid();
    chk("t6_no_d_resp", bus.d_resp, 0);
    chk("t6_no_i_resp", bus.i_resp, 0);
    go();
    bus.mem_resp = 0;
    go(); mid();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
